// File: rtl/pcs_gray_pkg.sv
// Shared Gray-code helpers for the PCS pointer and timer counters.
// Latency: none (functions and constants only).
// Backpressure: none.
//
// Contents:
//   GRAY_MAX_W  widest counter the helpers support; counters check WIDTH against it
//   gray_word_t helper word, GRAY_MAX_W bits; narrower values are zero-extended
//   bin2gray    binary -> Gray
//   gray2bin    Gray -> binary (MSB-first XOR prefix)
package pcs_gray_pkg;

   localparam int GRAY_MAX_W = 16;

   typedef logic [GRAY_MAX_W-1:0] gray_word_t;

   // Zero-extension is harmless: leading zeros map to leading zeros in either direction.
   function automatic gray_word_t bin2gray(input gray_word_t b);
      return b ^ (b >> 1);
   endfunction

   function automatic gray_word_t gray2bin(input gray_word_t g);
      gray_word_t b;
      b = '0;
      b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
      for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

endpackage

// File: rtl/gray_to_bin.sv
// Combinational Gray -> binary decoder used on the counter's load path.
// Latency: 0 cycles (pure XOR prefix chain, MSB to LSB).
// Backpressure: none.
//
// Ports:
//   gray  in  WIDTH  Gray-coded value
//   bin   out WIDTH  binary equivalent
module gray_to_bin #(
   parameter int WIDTH = 5
) (
   input  logic [WIDTH-1:0] gray,
   output logic [WIDTH-1:0] bin
);

   // bin[i] is the XOR of all Gray bits at or above i; each stage reuses the one above.
   always_comb begin
      bin = '0;
      bin[WIDTH-1] = gray[WIDTH-1];
      for (int i = WIDTH - 2; i >= 0; i--) begin
         bin[i] = bin[i+1] ^ gray[i];
      end
   end

endmodule

// File: rtl/gray_counter_param.sv
// Parametrised Gray-code counter (up/down, sync load, wrap pulse) for CDC pointers and timers.
// Latency: 1 clk from sampled controls to gray_out/bin_out/wrap (all registered, no comb paths).
// Backpressure: none; enable=0 simply holds the count.
//
// Ports:
//   clk        in   1      clock, all logic on posedge
//   reset_n    in   1      synchronous active-low reset, overrides load/enable
//   enable     in   1      advance one step this cycle
//   up_dn      in   1      1 = up, 0 = down (only looked at with enable=1)
//   load       in   1      load load_gray this cycle (beats enable)
//   load_gray  in   WIDTH  Gray value to load
//   gray_out   out  WIDTH  registered Gray count
//   bin_out    out  WIDTH  registered binary count, always in step with gray_out
//   wrap       out  1      one-cycle pulse the cycle after a wrap step
//   sat        out  1      only when GRAY_CNT_SAT_EN is defined: count pinned at an end
//
// Build option GRAY_CNT_SAT_EN: steps past either end hold the count instead of wrapping,
// wrap stays 0 and the sat port is present.
module gray_counter_param
   import pcs_gray_pkg::*;
#(
   parameter int WIDTH     = 5,
   parameter int RESET_BIN = 0
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             enable,
   input  logic             up_dn,
   input  logic             load,
   input  logic [WIDTH-1:0] load_gray,
   output logic [WIDTH-1:0] gray_out,
   output logic [WIDTH-1:0] bin_out,
`ifdef GRAY_CNT_SAT_EN
   output logic             sat,
`endif
   output logic             wrap
);

   generate
      if (WIDTH < 2 || WIDTH > GRAY_MAX_W) begin : g_bad_width
         $error("gray_counter_param: WIDTH must be in 2..GRAY_MAX_W");
      end
   endgenerate

   localparam logic [WIDTH-1:0] CNT_MAX  = {WIDTH{1'b1}};
   localparam logic [WIDTH-1:0] CNT_MIN  = '0;
   localparam logic [WIDTH-1:0] RST_BIN  = WIDTH'(RESET_BIN);
   localparam logic [WIDTH-1:0] RST_GRAY = WIDTH'(bin2gray(gray_word_t'(RESET_BIN)));

   logic [WIDTH-1:0] bin_q;
   logic [WIDTH-1:0] gray_q;
   logic             wrap_q;
   logic [WIDTH-1:0] load_bin;
   logic [WIDTH-1:0] bin_nxt;
   logic [WIDTH-1:0] gray_nxt;
   logic             wrap_nxt;
`ifdef GRAY_CNT_SAT_EN
   logic             sat_q;
   logic             sat_nxt;
`endif

   gray_to_bin #(
      .WIDTH (WIDTH)
   ) u_load_dec (
      .gray (load_gray),
      .bin  (load_bin)
   );

   // Next binary count and flags: load > enable > hold.
   always_comb begin
      bin_nxt  = bin_q;
      wrap_nxt = 1'b0;
`ifdef GRAY_CNT_SAT_EN
      sat_nxt  = sat_q;
`endif
      if (load) begin
         bin_nxt = load_bin;
`ifdef GRAY_CNT_SAT_EN
         sat_nxt = 1'b0;
`endif
      end else if (enable) begin
         if (up_dn) begin
            if (bin_q == CNT_MAX) begin
`ifdef GRAY_CNT_SAT_EN
               sat_nxt  = 1'b1;
`else
               bin_nxt  = CNT_MIN;
               wrap_nxt = 1'b1;
`endif
            end else begin
               bin_nxt = bin_q + WIDTH'(1);
`ifdef GRAY_CNT_SAT_EN
               sat_nxt = 1'b0;
`endif
            end
         end else begin
            if (bin_q == CNT_MIN) begin
`ifdef GRAY_CNT_SAT_EN
               sat_nxt  = 1'b1;
`else
               bin_nxt  = CNT_MAX;
               wrap_nxt = 1'b1;
`endif
            end else begin
               bin_nxt = bin_q - WIDTH'(1);
`ifdef GRAY_CNT_SAT_EN
               sat_nxt = 1'b0;
`endif
            end
         end
      end
   end

   // Gray is encoded from next-b so both views land on the same edge and never skew.
   always_comb begin
      gray_nxt = WIDTH'(bin2gray(gray_word_t'(bin_nxt)));
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         bin_q  <= RST_BIN;
         gray_q <= RST_GRAY;
         wrap_q <= 1'b0;
`ifdef GRAY_CNT_SAT_EN
         sat_q  <= 1'b0;
`endif
      end else begin
         bin_q  <= bin_nxt;
         gray_q <= gray_nxt;
         wrap_q <= wrap_nxt;
`ifdef GRAY_CNT_SAT_EN
         sat_q  <= sat_nxt;
`endif
      end
   end

   assign gray_out = gray_q;
   assign bin_out  = bin_q;
   assign wrap     = wrap_q;
`ifdef GRAY_CNT_SAT_EN
   assign sat      = sat_q;
`endif

endmodule

// File: tb/tb_gray_counter_param.sv
module tb_gray_counter_param;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       enable;
   logic       up_dn;
   logic       load;
   logic [4:0] load_gray;
   logic [4:0] gray_out, bin_out;
   logic [4:0] gray_out3, bin_out3;
   logic       wrap, wrap3;
`ifdef GRAY_CNT_SAT_EN
   logic       sat, sat3;
`endif

   int nvec = 0;
   int nerr = 0;

   // Hand-written 5-bit Gray sequence for counts 0..31.
   logic [4:0] gtbl [32] = '{5'h00, 5'h01, 5'h03, 5'h02, 5'h06, 5'h07, 5'h05, 5'h04,
                             5'h0C, 5'h0D, 5'h0F, 5'h0E, 5'h0A, 5'h0B, 5'h09, 5'h08,
                             5'h18, 5'h19, 5'h1B, 5'h1A, 5'h1E, 5'h1F, 5'h1D, 5'h1C,
                             5'h14, 5'h15, 5'h17, 5'h16, 5'h12, 5'h13, 5'h11, 5'h10};

   gray_counter_param #(.WIDTH(5), .RESET_BIN(0)) dut (
      .clk (clk), .reset_n (reset_n), .enable (enable), .up_dn (up_dn),
      .load (load), .load_gray (load_gray), .gray_out (gray_out), .bin_out (bin_out),
`ifdef GRAY_CNT_SAT_EN
      .sat (sat),
`endif
      .wrap (wrap)
   );

   gray_counter_param #(.WIDTH(5), .RESET_BIN(3)) dut3 (
      .clk (clk), .reset_n (reset_n), .enable (enable), .up_dn (up_dn),
      .load (load), .load_gray (load_gray), .gray_out (gray_out3), .bin_out (bin_out3),
`ifdef GRAY_CNT_SAT_EN
      .sat (sat3),
`endif
      .wrap (wrap3)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step(input logic en, input logic ud, input logic ld, input logic [4:0] lg);
      enable    = en;
      up_dn     = ud;
      load      = ld;
      load_gray = lg;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [4:0] ref_g2b(input logic [4:0] g);
      logic [4:0] b;
      b[4] = g[4];
      for (int i = 3; i >= 0; i--) b[i] = b[i+1] ^ g[i];
      return b;
   endfunction

   initial begin
      logic [4:0] prev_g;
      logic [4:0] mb, prev_mb;
      logic       mw, ms;
      logic       en, ud, ld;
      logic [4:0] lg;

      // ---- reset state (both RESET_BIN variants)
      reset_n = 1'b0;
      step(1'b0, 1'b1, 1'b0, 5'h00);
      check("rst_gray", gray_out, 5'h00);
      check("rst_bin", bin_out, 5'h00);
      check("rst_wrap", wrap, 1'b0);
      check("rst3_gray", gray_out3, 5'h02);
      check("rst3_bin", bin_out3, 5'h03);
`ifdef GRAY_CNT_SAT_EN
      check("rst_sat", sat, 1'b0);
`endif
      reset_n = 1'b1;

      // ---- 1: 32 up steps through the wrap
      for (int k = 1; k <= 32; k++) begin
         prev_g = gray_out;
         step(1'b1, 1'b1, 1'b0, 5'h00);
`ifdef GRAY_CNT_SAT_EN
         if (k == 32) begin
            check("up_sat_gray", gray_out, 5'h10);
            check("up_sat_bin", bin_out, 5'd31);
            check("up_sat_wrap", wrap, 1'b0);
            check("up_sat_sat", sat, 1'b1);
            check("up_sat_chg", $countones(gray_out ^ prev_g), 0);
         end else begin
            check("up_gray", gray_out, gtbl[k]);
            check("up_bin", bin_out, k);
            check("up_sat", sat, 1'b0);
            check("up_chg", $countones(gray_out ^ prev_g), 1);
         end
`else
         check("up_gray", gray_out, gtbl[k % 32]);
         check("up_bin", bin_out, k % 32);
         check("up_wrap", wrap, (k == 32) ? 1'b1 : 1'b0);
         check("up_chg", $countones(gray_out ^ prev_g), 1);
`endif
      end

      // ---- 2: down step from 0
      reset_n = 1'b0;
      step(1'b0, 1'b1, 1'b0, 5'h00);
      reset_n = 1'b1;
      step(1'b1, 1'b0, 1'b0, 5'h00);
`ifdef GRAY_CNT_SAT_EN
      check("dn0_gray", gray_out, 5'h00);
      check("dn0_bin", bin_out, 5'd0);
      check("dn0_wrap", wrap, 1'b0);
      check("dn0_sat", sat, 1'b1);
      step(1'b0, 1'b0, 1'b0, 5'h00);
      check("idle_sat_hold", sat, 1'b1);
      step(1'b1, 1'b1, 1'b0, 5'h00);
      check("up1_gray", gray_out, 5'h01);
      check("up1_sat", sat, 1'b0);
`else
      check("dn0_gray", gray_out, 5'h10);
      check("dn0_bin", bin_out, 5'd31);
      check("dn0_wrap", wrap, 1'b1);
      step(1'b1, 1'b0, 1'b0, 5'h00);
      check("dn1_gray", gray_out, 5'h11);
      check("dn1_bin", bin_out, 5'd30);
      check("dn1_wrap", wrap, 1'b0);
`endif

      // ---- 3: load beats enable
      step(1'b1, 1'b1, 1'b1, 5'b01100);
      check("ld_gray", gray_out, 5'b01100);
      check("ld_bin", bin_out, 5'd8);
      check("ld_wrap", wrap, 1'b0);
      step(1'b1, 1'b1, 1'b0, 5'h00);
      check("ld_up_gray", gray_out, 5'b01101);
      check("ld_up_bin", bin_out, 5'd9);
      prev_g = gray_out;
      step(1'b0, 1'b0, 1'b0, 5'h00);
      check("idle_gray", gray_out, prev_g);
      check("idle_wrap", wrap, 1'b0);

      // ---- 4: random traffic against a binary reference model (count is 9 here)
      mb = 5'd9;
      ms = 1'b0;
      for (int n = 0; n < 10000; n++) begin
         en = ($urandom_range(0, 3) != 0);
         ud = $urandom_range(0, 1) == 1;
         ld = ($urandom_range(0, 15) == 0);
         lg = 5'($urandom_range(0, 31));
         prev_g  = gray_out;
         prev_mb = mb;
         mw = 1'b0;
         if (ld) begin
            mb = ref_g2b(lg);
            ms = 1'b0;
         end else if (en) begin
            if (ud && mb == 5'd31) begin
`ifdef GRAY_CNT_SAT_EN
               ms = 1'b1;
`else
               mb = 5'd0; mw = 1'b1;
`endif
            end else if (!ud && mb == 5'd0) begin
`ifdef GRAY_CNT_SAT_EN
               ms = 1'b1;
`else
               mb = 5'd31; mw = 1'b1;
`endif
            end else begin
               mb = ud ? mb + 5'd1 : mb - 5'd1;
               ms = 1'b0;
            end
         end
         step(en, ud, ld, lg);
         check("rnd_bin", bin_out, mb);
         check("rnd_gray", gray_out, mb ^ (mb >> 1));
         check("rnd_wrap", wrap, mw);
`ifdef GRAY_CNT_SAT_EN
         check("rnd_sat", sat, ms);
`endif
         if (!ld)
            check("rnd_chg", $countones(gray_out ^ prev_g), (mb != prev_mb) ? 1 : 0);
      end

      // ---- 5: reset mid-count with enable high
      step(1'b0, 1'b1, 1'b1, 5'b01111);
      check("pre_rst_bin", bin_out, 5'd10);
      reset_n = 1'b0;
      step(1'b1, 1'b1, 1'b0, 5'h00);
      check("mid_rst_gray", gray_out, 5'h00);
      check("mid_rst3_gray", gray_out3, 5'b00010);
      check("mid_rst3_bin", bin_out3, 5'd3);
      check("mid_rst3_wrap", wrap3, 1'b0);
      reset_n = 1'b1;

`ifdef GRAY_CNT_SAT_EN
      // ---- 6: saturation at the top
      step(1'b0, 1'b1, 1'b1, 5'b10000);
      check("sat_ld_bin", bin_out, 5'd31);
      check("sat_ld_sat", sat, 1'b0);
      for (int k = 0; k < 3; k++) begin
         step(1'b1, 1'b1, 1'b0, 5'h00);
         check("sat_hold_gray", gray_out, 5'b10000);
         check("sat_hold_sat", sat, 1'b1);
         check("sat_hold_wrap", wrap, 1'b0);
      end
      step(1'b1, 1'b0, 1'b0, 5'h00);
      check("sat_dn_gray", gray_out, 5'b10001);
      check("sat_dn_bin", bin_out, 5'd30);
      check("sat_dn_sat", sat, 1'b0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
